control_pipeline: RTL and testbench



---
 rtl/control_pkg.sv | 60 ++++++
 rtl/control_pipeline_if.sv | 37 +++
 rtl/control_decode.sv | 68 ++++++
 rtl/control_pipeline.sv | 121 ++++++++++++
 tb/tb_control_pipeline.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/control_pkg.sv
// Shared types for the control pipeline: opcodes, ALU select encoding,
// the packed per-stage control bundle and register-use helpers.
package control_pkg;

    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_NOP        = 4'd0,
        ALU_ARITHMETIC = 4'd1,
        ALU_LOAD       = 4'd2,
        ALU_STORE      = 4'd3,
        ALU_BRANCH     = 4'd4,
        ALU_JAL        = 4'd5,
        ALU_JALR       = 4'd6,
        ALU_LUI        = 4'd7,
        ALU_AUIPC      = 4'd8
    } alu_sel_e;

    // First-listed field is the MSB; illegal lands in bit 0.
    typedef struct packed {
        logic       regfile_wr_en;
        logic       reg_b_select;
        logic       mem_data_select;
        logic       mem_rd_en;
        logic       mem_wr_en;
        logic       is_branch;
        logic       is_jal;
        logic       is_jalr;
        alu_sel_e   alu_select;
        logic [2:0] mem_size;
        logic       illegal;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // Instructions that read rs1 and can therefore hit a load-use hazard on it.
    function automatic logic uses_rs1(input logic [6:0] opcode);
        case (opcode)
            OP_ALU, OP_ALUI, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Instructions that read rs2.
    function automatic logic uses_rs2(input logic [6:0] opcode);
        case (opcode)
            OP_ALU, OP_STORE, OP_BRANCH: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/control_pipeline_if.sv
// Bundle of ID-side inputs, pipeline control and per-stage outputs.
interface control_pipeline_if #(
    parameter int NUM_STAGES = 3,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    import control_pkg::*;

    logic                           id_valid;
    logic [6:0]                     id_opcode;
    logic [2:0]                     id_funct3;
    logic [REG_ADDR_W-1:0]          id_rd;
    logic [REG_ADDR_W-1:0]          id_rs1;
    logic [REG_ADDR_W-1:0]          id_rs2;
    logic                           stall_in;
    logic                           flush;
    logic                           id_ready;
    logic                           hazard_stall;
    logic [NUM_STAGES-1:0]          stage_valid;
    logic [NUM_STAGES*CTRL_W-1:0]   stage_ctrl;
    logic [NUM_STAGES*REG_ADDR_W-1:0] stage_rd;
    logic [CNT_W-1:0]               perf_hazard_cnt;
    logic [CNT_W-1:0]               perf_flush_cnt;

    modport master (
        output id_valid, id_opcode, id_funct3, id_rd, id_rs1, id_rs2, stall_in, flush,
        input  id_ready, hazard_stall, stage_valid, stage_ctrl, stage_rd,
               perf_hazard_cnt, perf_flush_cnt
    );

    modport slave (
        input  id_valid, id_opcode, id_funct3, id_rd, id_rs1, id_rs2, stall_in, flush,
        output id_ready, hazard_stall, stage_valid, stage_ctrl, stage_rd,
               perf_hazard_cnt, perf_flush_cnt
    );

endinterface

// File: rtl/control_decode.sv
// Purely combinational opcode/funct3 to control-bundle decoder.
module control_decode
    import control_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    output ctrl_t      ctrl_o
);

    // Start from an all-zero bundle and raise only the fields each opcode needs.
    always_comb begin
        ctrl_o = '0;
        case (opcode_i)
            OP_ALU: begin
                ctrl_o.regfile_wr_en = 1'b1;
                ctrl_o.reg_b_select  = 1'b1;
                ctrl_o.alu_select    = ALU_ARITHMETIC;
            end
            OP_ALUI: begin
                ctrl_o.regfile_wr_en = 1'b1;
                ctrl_o.alu_select    = ALU_ARITHMETIC;
            end
            OP_LOAD: begin
                ctrl_o.regfile_wr_en   = 1'b1;
                ctrl_o.mem_data_select = 1'b1;
                ctrl_o.mem_rd_en       = 1'b1;
                ctrl_o.alu_select      = ALU_LOAD;
                ctrl_o.mem_size        = funct3_i;
            end
            OP_STORE: begin
                ctrl_o.mem_wr_en  = 1'b1;
                ctrl_o.alu_select = ALU_STORE;
                ctrl_o.mem_size   = funct3_i;
            end
            OP_BRANCH: begin
                ctrl_o.reg_b_select = 1'b1;
                ctrl_o.is_branch    = 1'b1;
                ctrl_o.alu_select   = ALU_BRANCH;
            end
            OP_JAL: begin
                ctrl_o.regfile_wr_en = 1'b1;
                ctrl_o.reg_b_select  = 1'b1;
                ctrl_o.is_jal        = 1'b1;
                ctrl_o.alu_select    = ALU_JAL;
            end
            OP_JALR: begin
                ctrl_o.regfile_wr_en = 1'b1;
                ctrl_o.reg_b_select  = 1'b1;
                ctrl_o.is_jalr       = 1'b1;
                ctrl_o.alu_select    = ALU_JALR;
            end
            OP_LUI: begin
                ctrl_o.regfile_wr_en = 1'b1;
                ctrl_o.reg_b_select  = 1'b1;
                ctrl_o.alu_select    = ALU_LUI;
            end
            OP_AUIPC: begin
                ctrl_o.regfile_wr_en = 1'b1;
                ctrl_o.reg_b_select  = 1'b1;
                ctrl_o.alu_select    = ALU_AUIPC;
            end
            default: begin
                ctrl_o.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/control_pipeline.sv
// Decodes the ID instruction and carries its control bundle through
// NUM_STAGES registers with stall, flush, load-use bubbles and perf counters.
module control_pipeline
    import control_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    control_pipeline_if.slave bus
);

    logic                  valid_q [NUM_STAGES];
    ctrl_t                 ctrl_q  [NUM_STAGES];
    logic [REG_ADDR_W-1:0] rd_q    [NUM_STAGES];

    logic                  s0_valid_d;
    ctrl_t                 s0_ctrl_d;
    logic [REG_ADDR_W-1:0] s0_rd_d;

    logic                  flush_pending_q, flush_pending_d;
    logic [CNT_W-1:0]      hazard_cnt_q, hazard_cnt_d;
    logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;

    ctrl_t                 id_ctrl;
    logic                  rs1_hit, rs2_hit;
    logic                  hazard;
    logic                  eflush;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    control_decode u_decode (
        .opcode_i (bus.id_opcode),
        .funct3_i (bus.id_funct3),
        .ctrl_o   (id_ctrl)
    );

    // Load in EX whose destination feeds a source the ID instruction actually reads.
    assign rs1_hit = (rd_q[0] == bus.id_rs1) && uses_rs1(bus.id_opcode);
    assign rs2_hit = (rd_q[0] == bus.id_rs2) && uses_rs2(bus.id_opcode);
    assign hazard  = !rst && bus.id_valid && valid_q[0] && ctrl_q[0].mem_rd_en &&
                     (rd_q[0] != '0) && (rs1_hit || rs2_hit);

    // A flush seen during a stall is remembered and applied on release.
    assign eflush = bus.flush || flush_pending_q;

    assign bus.hazard_stall = hazard;
    // A squashed ID instruction is consumed even if it would have hazarded.
    assign bus.id_ready     = !rst && !bus.stall_in && (eflush || !hazard);

    // Stage-0 entry, pending-flush and counter next state, in priority order.
    always_comb begin
        s0_valid_d      = 1'b0;
        s0_ctrl_d       = '0;
        s0_rd_d         = '0;
        flush_pending_d = 1'b0;
        hazard_cnt_d    = hazard_cnt_q;
        flush_cnt_d     = flush_cnt_q;
        if (bus.stall_in) begin
            flush_pending_d = flush_pending_q | bus.flush;
        end else if (eflush) begin
            if (bus.id_valid) begin
                flush_cnt_d = sat_inc(flush_cnt_q);
            end
        end else if (hazard) begin
            hazard_cnt_d = sat_inc(hazard_cnt_q);
        end else if (bus.id_valid) begin
            s0_valid_d = 1'b1;
            s0_ctrl_d  = id_ctrl;
            s0_rd_d    = bus.id_rd;
        end
    end

    // Stage registers: everything freezes on stall, otherwise shift one stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                valid_q[k] <= 1'b0;
                ctrl_q[k]  <= '0;
                rd_q[k]    <= '0;
            end
        end else if (!bus.stall_in) begin
            valid_q[0] <= s0_valid_d;
            ctrl_q[0]  <= s0_ctrl_d;
            rd_q[0]    <= s0_rd_d;
            for (int k = 1; k < NUM_STAGES; k++) begin
                valid_q[k] <= valid_q[k-1];
                ctrl_q[k]  <= ctrl_q[k-1];
                rd_q[k]    <= rd_q[k-1];
            end
        end
    end

    // Pending flush and saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_pending_q <= 1'b0;
            hazard_cnt_q    <= '0;
            flush_cnt_q     <= '0;
        end else begin
            flush_pending_q <= flush_pending_d;
            hazard_cnt_q    <= hazard_cnt_d;
            flush_cnt_q     <= flush_cnt_d;
        end
    end

    // Flatten per-stage state onto the output buses, stage 0 in the LSBs.
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_out
        assign bus.stage_valid[gi]                          = valid_q[gi];
        assign bus.stage_ctrl[gi*CTRL_W +: CTRL_W]          = ctrl_q[gi];
        assign bus.stage_rd[gi*REG_ADDR_W +: REG_ADDR_W]    = rd_q[gi];
    end

    assign bus.perf_hazard_cnt = hazard_cnt_q;
    assign bus.perf_flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_control_pipeline.sv
// Directed plus randomized bench for control_pipeline against a stage-list model.
`timescale 1ns/1ps
module tb_control_pipeline;
    import control_pkg::*;

    localparam int NS = 3;
    localparam int RW = 5;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    control_pipeline_if #(.NUM_STAGES(NS), .REG_ADDR_W(RW), .CNT_W(CW)) bus ();

    control_pipeline #(.NUM_STAGES(NS), .REG_ADDR_W(RW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model: list of stage contents plus counters and the remembered flush.
    logic          m_valid [NS];
    ctrl_t         m_ctrl  [NS];
    logic [RW-1:0] m_rd    [NS];
    int            m_hcnt, m_fcnt;
    bit            m_pend;

    function automatic ctrl_t ref_decode(input logic [6:0] op, input logic [2:0] f3);
        ctrl_t c;
        c = '0;
        case (op)
            7'b0110011: begin c.regfile_wr_en = 1; c.reg_b_select = 1; c.alu_select = ALU_ARITHMETIC; end
            7'b0010011: begin c.regfile_wr_en = 1; c.alu_select = ALU_ARITHMETIC; end
            7'b0000011: begin c.regfile_wr_en = 1; c.mem_data_select = 1; c.mem_rd_en = 1; c.alu_select = ALU_LOAD; end
            7'b0100011: begin c.mem_wr_en = 1; c.alu_select = ALU_STORE; end
            7'b1100011: begin c.reg_b_select = 1; c.is_branch = 1; c.alu_select = ALU_BRANCH; end
            7'b1101111: begin c.regfile_wr_en = 1; c.reg_b_select = 1; c.is_jal = 1; c.alu_select = ALU_JAL; end
            7'b1100111: begin c.regfile_wr_en = 1; c.reg_b_select = 1; c.is_jalr = 1; c.alu_select = ALU_JALR; end
            7'b0110111: begin c.regfile_wr_en = 1; c.reg_b_select = 1; c.alu_select = ALU_LUI; end
            7'b0010111: begin c.regfile_wr_en = 1; c.reg_b_select = 1; c.alu_select = ALU_AUIPC; end
            default:    c.illegal = 1;
        endcase
        if (op == 7'b0000011 || op == 7'b0100011) c.mem_size = f3;
        return c;
    endfunction

    function automatic bit ref_use1(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};
    endfunction

    function automatic bit ref_use2(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [6:0] op, input logic [2:0] f3,
                          input logic [RW-1:0] rd, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2);
        bus.id_valid  = v;
        bus.id_opcode = op;
        bus.id_funct3 = f3;
        bus.id_rd     = rd;
        bus.id_rs1    = rs1;
        bus.id_rs2    = rs2;
    endtask

    // One clock: check combinational outputs, advance model, check registered state.
    task automatic cycle();
        bit h, ef;
        logic [NS-1:0]        ev;
        logic [NS*CTRL_W-1:0] ec;
        logic [NS*RW-1:0]     er;
        #1;
        ef = bus.flush || m_pend;
        h  = !rst && bus.id_valid && m_valid[0] && m_ctrl[0].mem_rd_en && (m_rd[0] != 0) &&
             ((m_rd[0] == bus.id_rs1 && ref_use1(bus.id_opcode)) ||
              (m_rd[0] == bus.id_rs2 && ref_use2(bus.id_opcode)));
        chk("hazard_stall", bus.hazard_stall, h);
        chk("id_ready", bus.id_ready, !rst && !bus.stall_in && (ef || !h));
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < NS; k++) begin m_valid[k] = 0; m_ctrl[k] = '0; m_rd[k] = '0; end
            m_hcnt = 0; m_fcnt = 0; m_pend = 0;
        end else if (bus.stall_in) begin
            m_pend = m_pend | bus.flush;
        end else begin
            m_pend = 0;
            for (int k = NS - 1; k > 0; k--) begin
                m_valid[k] = m_valid[k-1]; m_ctrl[k] = m_ctrl[k-1]; m_rd[k] = m_rd[k-1];
            end
            m_valid[0] = 0; m_ctrl[0] = '0; m_rd[0] = '0;
            if (ef) begin
                if (bus.id_valid && m_fcnt < CMAX) m_fcnt++;
            end else if (h) begin
                if (m_hcnt < CMAX) m_hcnt++;
            end else if (bus.id_valid) begin
                m_valid[0] = 1;
                m_ctrl[0]  = ref_decode(bus.id_opcode, bus.id_funct3);
                m_rd[0]    = bus.id_rd;
            end
        end
        #1;
        for (int k = 0; k < NS; k++) begin
            ev[k] = m_valid[k];
            ec[k*CTRL_W +: CTRL_W] = m_ctrl[k];
            er[k*RW +: RW] = m_rd[k];
        end
        chk("stage_valid", bus.stage_valid, ev);
        chk("stage_ctrl", bus.stage_ctrl, ec);
        chk("stage_rd", bus.stage_rd, er);
        chk("perf_hazard_cnt", bus.perf_hazard_cnt, m_hcnt);
        chk("perf_flush_cnt", bus.perf_flush_cnt, m_fcnt);
        $display("cyc t=%0t rst=%0b v=%0b op=%b stall=%0b flush=%0b -> sv=%b hz=%0d fl=%0d",
                 $time, rst, bus.id_valid, bus.id_opcode, bus.stall_in, bus.flush,
                 bus.stage_valid, bus.perf_hazard_cnt, bus.perf_flush_cnt);
    endtask

    logic [6:0] ops [10];
    ctrl_t c;

    initial begin
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
        for (int k = 0; k < NS; k++) begin m_valid[k] = 0; m_ctrl[k] = '0; m_rd[k] = '0; end
        m_hcnt = 0; m_fcnt = 0; m_pend = 0;

        // Reset
        rst = 1; bus.stall_in = 0; bus.flush = 0;
        set_id(1, 7'b0110011, 0, 1, 2, 3);
        cycle(); cycle();
        chk("reset_valid", bus.stage_valid, 0);
        chk("reset_ctrl", bus.stage_ctrl, 0);
        rst = 0;

        // ALU for one cycle, then follow it to stage 2
        set_id(1, 7'b0110011, 3'b000, 7, 1, 2); cycle();
        c = ctrl_t'(bus.stage_ctrl[0 +: CTRL_W]);
        chk("alu_s0_valid", bus.stage_valid[0], 1'b1);
        chk("alu_wr_en", c.regfile_wr_en, 1'b1);
        chk("alu_b_sel", c.reg_b_select, 1'b1);
        set_id(0, 0, 0, 0, 0, 0); cycle(); cycle();
        chk("alu_s2_valid", bus.stage_valid[2], 1'b1);
        chk("alu_s2_rd", bus.stage_rd[2*RW +: RW], 5'd7);

        // Load-use on rs1
        set_id(1, 7'b0000011, 3'b010, 5, 0, 0); cycle();
        set_id(1, 7'b0110011, 3'b000, 6, 5, 9);
        #1 chk("lu_hazard", bus.hazard_stall, 1'b1);
        chk("lu_not_ready", bus.id_ready, 1'b0);
        cycle();
        chk("lu_bubble", bus.stage_valid[0], 1'b0);
        chk("lu_hcnt", bus.perf_hazard_cnt, 4'd1);
        cycle();
        chk("lu_add_in", bus.stage_rd[0 +: RW], 5'd6);

        // Load to x0 never stalls
        set_id(1, 7'b0000011, 3'b010, 0, 0, 0); cycle();
        set_id(1, 7'b0110011, 3'b000, 6, 0, 0);
        #1 chk("x0_no_hazard", bus.hazard_stall, 1'b0);
        cycle();

        // Flush with BRANCH in EX and JAL in ID
        set_id(1, 7'b1100011, 3'b000, 0, 1, 2); cycle();
        set_id(1, 7'b1101111, 3'b000, 1, 0, 0); bus.flush = 1; cycle();
        bus.flush = 0;
        c = ctrl_t'(bus.stage_ctrl[CTRL_W +: CTRL_W]);
        chk("fl_s0_bubble", bus.stage_valid[0], 1'b0);
        chk("fl_s1_branch", c.is_branch, 1'b1);
        chk("fl_cnt", bus.perf_flush_cnt, 4'd1);

        // Flush held through a stall, released later
        set_id(1, 7'b0010011, 3'b000, 4, 1, 0); cycle();
        bus.stall_in = 1; bus.flush = 1; cycle(); cycle(); cycle();
        bus.flush = 0; cycle();
        chk("sf_frozen_s0", bus.stage_rd[0 +: RW], 5'd4);
        bus.stall_in = 0; cycle();
        chk("sf_squash", bus.stage_valid[0], 1'b0);
        chk("sf_fcnt", bus.perf_flush_cnt, 4'd2);
        cycle();
        chk("sf_once", bus.stage_valid[0], 1'b1);

        // Illegal opcode and SW
        set_id(1, 7'b1111111, 3'b010, 3, 0, 0); cycle();
        chk("illegal_ctrl", bus.stage_ctrl[0 +: CTRL_W], 16'h0001);
        set_id(1, 7'b0100011, 3'b010, 0, 1, 2); cycle();
        c = ctrl_t'(bus.stage_ctrl[0 +: CTRL_W]);
        chk("sw_wr_en", c.mem_wr_en, 1'b1);
        chk("sw_size", c.mem_size, 3'b010);

        // Drive the hazard counter past its ceiling
        for (int i = 0; i < (1 << CW) + 3; i++) begin
            set_id(1, 7'b0000011, 3'b000, 3, 0, 0); cycle();
            set_id(1, 7'b0110011, 3'b000, 8, 0, 3); cycle(); cycle();
        end
        chk("hcnt_saturated", bus.perf_hazard_cnt, 4'd15);

        // Reset mid-stream
        set_id(1, 7'b0110011, 3'b000, 2, 1, 1); cycle(); cycle();
        rst = 1; cycle();
        chk("midrst_valid", bus.stage_valid, 0);
        chk("midrst_hcnt", bus.perf_hazard_cnt, 0);
        rst = 0;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) < 2);
            bus.stall_in = ($urandom_range(0, 99) < 20);
            bus.flush = ($urandom_range(0, 99) < 12);
            set_id($urandom_range(0, 99) < 80, ops[$urandom_range(0, 9)], 3'($urandom_range(0, 7)),
                   RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
